wb_stage_ext: RTL and testbench
===============================

WB_STAGE_EXT -- requirements
Module: wb_stage_ext

Interface
REQ-001 Parameter DW, default 32, datapath width in bits; SHALL be 32 or 64.
REQ-002 Parameter AW, default 5, register-address width.
REQ-003 Parameter TAGW, default 4, width of instruction type/number trace tags.
REQ-004 Parameter CNTW, default 32, retired-instruction counter width.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-low.
REQ-007 mem_valid  input  1  MEM stage holds a real instruction.
REQ-008 mem_destR  input  AW  destination register address.
REQ-009 mem_aluR  input  DW  ALU result; also the load address.
REQ-010 mem_mdata  input  DW  raw memory read word.
REQ-011 mem_wreg  input  1  instruction writes the register file.
REQ-012 mem_m2reg  input  1  writeback source: 1 = memory, 0 = ALU.
REQ-013 mem_ldsize  input  2  load size: 00 byte, 01 half, 10 word32, 11 full DW.
REQ-014 mem_ldsign  input  1  1 = sign-extend, 0 = zero-extend.
REQ-015 wb_stall  input  1  hold WB register contents.
REQ-016 wb_flush  input  1  insert a bubble.
REQ-017 MEM_ins_type, MEM_ins_number  input  TAGW each  trace tags.
REQ-018 wb_valid  output  1  registered valid.
REQ-019 wb_wreg  output  1  registered write enable.
REQ-020 wb_destR  output  AW  registered destination address.
REQ-021 wb_dest  output  DW  registered writeback data.
REQ-022 WB_ins_type, WB_ins_number  output  TAGW each  registered trace tags.
REQ-023 wb_retired  output  CNTW  count of instructions retired.

Function
REQ-024 Update priority per edge SHALL be: reset, then flush, then stall, then load.
REQ-025 Load, i.e. no stall and no flush: every output SHALL take its next value one cycle after the inputs, latency 1.
REQ-026 On load, wb_valid SHALL equal mem_valid, and wb_wreg SHALL equal mem_valid AND mem_wreg AND (mem_destR != 0).
REQ-027 On load, wb_destR, WB_ins_type and WB_ins_number SHALL capture their MEM inputs.
REQ-028 With mem_m2reg=0, wb_dest SHALL be mem_aluR.
REQ-029 With mem_m2reg=1, byte offset off = mem_aluR[log2(DW/8)-1:0]; the extracted field SHALL be:
  - byte: mem_mdata[off*8 +: 8]
  - half: bits at (off with bit0 cleared)*8, 16 wide
  - word32: bits at (off with bits[1:0] cleared)*8, 32 wide
  - full: mem_mdata
REQ-030 Misaligned offsets SHALL be silently aligned down; no exception is raised.
REQ-031 The extracted field SHALL be extended to DW: sign-extend if mem_ldsign=1, zero-extend otherwise.
REQ-032 When DW=32, ldsize 11 SHALL behave as word32; ldsign is ignored for full-width loads.
REQ-033 Stall without flush: all outputs SHALL hold, and wb_retired SHALL not increment.
REQ-034 Flush, regardless of stall: wb_valid=0 and wb_wreg=0; wb_destR, wb_dest and tags SHALL hold; no retire.
REQ-035 wb_retired SHALL increment by 1 on each load edge with mem_valid=1, wrapping from 2^CNTW-1 to 0.
REQ-036 No combinational path SHALL exist from any input to any output.

Reset
REQ-037 When rst=0 at a rising edge, all outputs, including wb_retired, SHALL become 0, overriding stall and flush.
REQ-038 Reset asserted mid-stream SHALL discard the in-flight entry, and the first post-reset edge SHALL load normally.

Verification
REQ-039 DW=32, aluR=0x3, mdata=0x80FF_1234, m2reg=1, ldsize=00, ldsign=1 -> next cycle wb_dest=0xFFFF_FF80.
REQ-040 Same stimulus with ldsize=01, ldsign=0 -> wb_dest=0x0000_80FF; with aluR=0x5, ldsize=10 -> wb_dest=0x80FF_1234.
REQ-041 mem_valid=1, wreg=1, destR=0 -> wb_valid=1, wb_wreg=0, and wb_retired increments by 1.
REQ-042 Load A, then stall 3 cycles while inputs change to B -> outputs stay A for 3 cycles, then show B; wb_retired rises by 2 in total.
REQ-043 Stall and flush asserted together -> wb_valid=0, wb_wreg=0, data holds, no retire; CNTW=4 with counter at 15 plus one valid load -> wb_retired=0.
REQ-044 rst=0 asserted with stall=1 and outputs nonzero -> all outputs 0 after the edge; rst=1 with mem_valid=1 -> loads on the next edge.

Source files
------------

// File: rtl/wb_stage_ext_if.sv
// MEM-to-WB bundle: MEM stage results in, registered writeback state and trace tags out.
interface wb_stage_ext_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int TAGW = 4,
    parameter int CNTW = 32
);
    logic            mem_valid;
    logic [AW-1:0]   mem_destR;
    logic [DW-1:0]   mem_aluR;
    logic [DW-1:0]   mem_mdata;
    logic            mem_wreg;
    logic            mem_m2reg;
    logic [1:0]      mem_ldsize;
    logic            mem_ldsign;
    logic            wb_stall;
    logic            wb_flush;
    logic [TAGW-1:0] MEM_ins_type;
    logic [TAGW-1:0] MEM_ins_number;

    logic            wb_valid;
    logic            wb_wreg;
    logic [AW-1:0]   wb_destR;
    logic [DW-1:0]   wb_dest;
    logic [TAGW-1:0] WB_ins_type;
    logic [TAGW-1:0] WB_ins_number;
    logic [CNTW-1:0] wb_retired;

    modport master (
        output mem_valid, mem_destR, mem_aluR, mem_mdata, mem_wreg, mem_m2reg,
               mem_ldsize, mem_ldsign, wb_stall, wb_flush, MEM_ins_type, MEM_ins_number,
        input  wb_valid, wb_wreg, wb_destR, wb_dest, WB_ins_type, WB_ins_number, wb_retired
    );

    modport slave (
        input  mem_valid, mem_destR, mem_aluR, mem_mdata, mem_wreg, mem_m2reg,
               mem_ldsize, mem_ldsign, wb_stall, wb_flush, MEM_ins_type, MEM_ins_number,
        output wb_valid, wb_wreg, wb_destR, wb_dest, WB_ins_type, WB_ins_number, wb_retired
    );
endinterface

// File: rtl/wb_stage_ext.sv
// Writeback pipeline register: load-data alignment/extension, write-enable qualification,
// stall/flush handling and a retired-instruction counter.
module wb_stage_ext #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int TAGW = 4,
    parameter int CNTW = 32
) (
    input logic           clk,
    input logic           rst,
    wb_stage_ext_if.slave bus
);
    localparam int              OFFW      = $clog2(DW / 8);
    localparam logic [OFFW-1:0] HALF_MASK = ~OFFW'(1);
    localparam logic [OFFW-1:0] WORD_MASK = ~OFFW'(3);
    localparam logic [DW-1:0]   MASK8     = DW'(8'hFF);
    localparam logic [DW-1:0]   MASK16    = DW'(16'hFFFF);
    localparam logic [DW-1:0]   MASK32    = DW'(32'hFFFF_FFFF);

    // Misaligned offsets are aligned down by masking; with DW=32 a full load equals word32.
    function automatic logic [DW-1:0] load_extend(
        input logic [DW-1:0]   word,
        input logic [OFFW-1:0] off,
        input logic [1:0]      size,
        input logic            sgn
    );
        logic [DW-1:0] sh;
        logic [DW-1:0] mask;
        logic          msb;
        sh   = word;
        mask = '1;
        msb  = 1'b0;
        case (size)
            2'b00: begin
                sh   = word >> {off, 3'b000};
                mask = MASK8;
                msb  = sh[7];
            end
            2'b01: begin
                sh   = word >> {off & HALF_MASK, 3'b000};
                mask = MASK16;
                msb  = sh[15];
            end
            2'b10: begin
                sh   = word >> {off & WORD_MASK, 3'b000};
                mask = MASK32;
                msb  = sh[31];
            end
            default: begin
                sh   = word;
                mask = '1;
                msb  = 1'b0;
            end
        endcase
        return (sgn && msb) ? (sh | ~mask) : (sh & mask);
    endfunction

    logic [DW-1:0]   data_p0;
    logic            wreg_p0;

    logic            vld_p1;
    logic            wreg_p1;
    logic [AW-1:0]   dest_r_p1;
    logic [DW-1:0]   data_p1;
    logic [TAGW-1:0] type_p1;
    logic [TAGW-1:0] num_p1;
    logic [CNTW-1:0] retired_p1;

    always_comb begin
        data_p0 = bus.mem_aluR;
        if (bus.mem_m2reg)
            data_p0 = load_extend(bus.mem_mdata, bus.mem_aluR[OFFW-1:0],
                                  bus.mem_ldsize, bus.mem_ldsign);
        wreg_p0 = bus.mem_valid && bus.mem_wreg && (bus.mem_destR != '0);
    end

    // p0 -> p1: reset beats flush, flush beats stall, stall beats load
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            wreg_p1    <= 1'b0;
            dest_r_p1  <= '0;
            data_p1    <= '0;
            type_p1    <= '0;
            num_p1     <= '0;
            retired_p1 <= '0;
        end else if (bus.wb_flush) begin
            vld_p1  <= 1'b0;
            wreg_p1 <= 1'b0;
        end else if (!bus.wb_stall) begin
            vld_p1    <= bus.mem_valid;
            wreg_p1   <= wreg_p0;
            dest_r_p1 <= bus.mem_destR;
            data_p1   <= data_p0;
            type_p1   <= bus.MEM_ins_type;
            num_p1    <= bus.MEM_ins_number;
            if (bus.mem_valid)
                retired_p1 <= retired_p1 + CNTW'(1);
        end
    end

    assign bus.wb_valid      = vld_p1;
    assign bus.wb_wreg       = wreg_p1;
    assign bus.wb_destR      = dest_r_p1;
    assign bus.wb_dest       = data_p1;
    assign bus.WB_ins_type   = type_p1;
    assign bus.WB_ins_number = num_p1;
    assign bus.wb_retired    = retired_p1;
endmodule

// File: tb/tb_wb_stage_ext.sv
// Directed bench for wb_stage_ext: a default instance plus a CNTW=4 instance for counter wrap.
module tb_wb_stage_ext;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    wb_stage_ext_if #(.DW(32), .AW(5), .TAGW(4), .CNTW(32)) bus ();
    wb_stage_ext_if #(.DW(32), .AW(5), .TAGW(4), .CNTW(4))  bus4 ();

    wb_stage_ext #(.DW(32), .AW(5), .TAGW(4), .CNTW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_stage_ext #(.DW(32), .AW(5), .TAGW(4), .CNTW(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.mem_valid      = bus.mem_valid;
    assign bus4.mem_destR      = bus.mem_destR;
    assign bus4.mem_aluR       = bus.mem_aluR;
    assign bus4.mem_mdata      = bus.mem_mdata;
    assign bus4.mem_wreg       = bus.mem_wreg;
    assign bus4.mem_m2reg      = bus.mem_m2reg;
    assign bus4.mem_ldsize     = bus.mem_ldsize;
    assign bus4.mem_ldsign     = bus.mem_ldsign;
    assign bus4.wb_stall       = bus.wb_stall;
    assign bus4.wb_flush       = bus.wb_flush;
    assign bus4.MEM_ins_type   = bus.MEM_ins_type;
    assign bus4.MEM_ins_number = bus.MEM_ins_number;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [4:0] dest_r, input logic [31:0] alu,
                         input logic [31:0] mdata, input logic wreg, input logic m2reg,
                         input logic [1:0] size, input logic sgn,
                         input logic [3:0] itype, input logic [3:0] inum);
        bus.mem_valid      = valid;
        bus.mem_destR      = dest_r;
        bus.mem_aluR       = alu;
        bus.mem_mdata      = mdata;
        bus.mem_wreg       = wreg;
        bus.mem_m2reg      = m2reg;
        bus.mem_ldsize     = size;
        bus.mem_ldsign     = sgn;
        bus.MEM_ins_type   = itype;
        bus.MEM_ins_number = inum;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus.wb_stall = 1'b0;
        bus.wb_flush = 1'b0;
        drive(1'b1, 5'd7, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd9, 4'd9);
        step();
        step();
        check_val("rst_valid", 64'(bus.wb_valid), 64'd0);
        check_val("rst_dest", 64'(bus.wb_dest), 64'd0);
        check_val("rst_destR", 64'(bus.wb_destR), 64'd0);
        check_val("rst_retired", 64'(bus.wb_retired), 64'd0);
        check_val("rst_retired4", 64'(bus4.wb_retired), 64'd0);

        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h3, 32'h80FF_1234, 1'b1, 1'b1, 2'b00, 1'b1, 4'd2, 4'd5);
        step();
        check_val("lb_sign_off3", 64'(bus.wb_dest), 64'hFFFF_FF80);
        check_val("lb_valid", 64'(bus.wb_valid), 64'd1);
        check_val("lb_wreg", 64'(bus.wb_wreg), 64'd1);
        check_val("lb_destR", 64'(bus.wb_destR), 64'd3);
        check_val("lb_type", 64'(bus.WB_ins_type), 64'd2);
        check_val("lb_num", 64'(bus.WB_ins_number), 64'd5);
        check_val("lb_retired", 64'(bus.wb_retired), 64'd1);

        drive(1'b1, 5'd3, 32'h3, 32'h80FF_1234, 1'b1, 1'b1, 2'b01, 1'b0, 4'd2, 4'd6);
        step();
        check_val("lh_zero_off3", 64'(bus.wb_dest), 64'h0000_80FF);

        drive(1'b1, 5'd3, 32'h5, 32'h80FF_1234, 1'b1, 1'b1, 2'b10, 1'b0, 4'd2, 4'd7);
        step();
        check_val("lw_off5", 64'(bus.wb_dest), 64'h80FF_1234);

        drive(1'b1, 5'd3, 32'h2, 32'h80FF_1234, 1'b1, 1'b1, 2'b11, 1'b1, 4'd2, 4'd8);
        step();
        check_val("lfull_dw32", 64'(bus.wb_dest), 64'h80FF_1234);

        drive(1'b1, 5'd3, 32'h1, 32'h80FF_1234, 1'b1, 1'b1, 2'b00, 1'b0, 4'd2, 4'd9);
        step();
        check_val("lbu_off1", 64'(bus.wb_dest), 64'h0000_0012);

        drive(1'b1, 5'd3, 32'h2, 32'h80FF_1234, 1'b1, 1'b1, 2'b01, 1'b1, 4'd2, 4'd10);
        step();
        check_val("lh_sign_off2", 64'(bus.wb_dest), 64'hFFFF_80FF);

        drive(1'b1, 5'd4, 32'hDEAD_BEEF, 32'h80FF_1234, 1'b1, 1'b0, 2'b00, 1'b1, 4'd1, 4'd11);
        step();
        check_val("alu_path", 64'(bus.wb_dest), 64'hDEAD_BEEF);
        check_val("alu_retired", 64'(bus.wb_retired), 64'd7);

        drive(1'b1, 5'd0, 32'h55, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 4'd12);
        step();
        check_val("r0_valid", 64'(bus.wb_valid), 64'd1);
        check_val("r0_wreg", 64'(bus.wb_wreg), 64'd0);
        check_val("r0_retired", 64'(bus.wb_retired), 64'd8);

        drive(1'b0, 5'd7, 32'h66, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 4'd13);
        step();
        check_val("bubble_valid", 64'(bus.wb_valid), 64'd0);
        check_val("bubble_wreg", 64'(bus.wb_wreg), 64'd0);
        check_val("bubble_destR", 64'(bus.wb_destR), 64'd7);
        check_val("bubble_retired", 64'(bus.wb_retired), 64'd8);

        drive(1'b1, 5'd9, 32'h1111_1111, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 4'd1);
        step();
        check_val("A_dest", 64'(bus.wb_dest), 64'h1111_1111);
        bus.wb_stall = 1'b1;
        drive(1'b1, 5'd10, 32'h2222_2222, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd3, 4'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("stall%0d_dest", i), 64'(bus.wb_dest), 64'h1111_1111);
            check_val($sformatf("stall%0d_destR", i), 64'(bus.wb_destR), 64'd9);
            check_val($sformatf("stall%0d_num", i), 64'(bus.WB_ins_number), 64'd1);
            check_val($sformatf("stall%0d_retired", i), 64'(bus.wb_retired), 64'd9);
        end
        bus.wb_stall = 1'b0;
        step();
        check_val("B_dest", 64'(bus.wb_dest), 64'h2222_2222);
        check_val("B_destR", 64'(bus.wb_destR), 64'd10);
        check_val("B_type", 64'(bus.WB_ins_type), 64'd3);
        check_val("B_retired", 64'(bus.wb_retired), 64'd10);

        bus.wb_stall = 1'b1;
        bus.wb_flush = 1'b1;
        drive(1'b1, 5'd12, 32'h3333_3333, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd5, 4'd5);
        step();
        check_val("flush_valid", 64'(bus.wb_valid), 64'd0);
        check_val("flush_wreg", 64'(bus.wb_wreg), 64'd0);
        check_val("flush_dest", 64'(bus.wb_dest), 64'h2222_2222);
        check_val("flush_destR", 64'(bus.wb_destR), 64'd10);
        check_val("flush_type", 64'(bus.WB_ins_type), 64'd3);
        check_val("flush_retired", 64'(bus.wb_retired), 64'd10);
        check_val("flush_retired4", 64'(bus4.wb_retired), 64'd10);
        bus.wb_stall = 1'b0;
        bus.wb_flush = 1'b0;

        for (int i = 0; i < 5; i++)
            step();
        check_val("cnt4_at15", 64'(bus4.wb_retired), 64'd15);
        bus.wb_stall = 1'b1;
        bus.wb_flush = 1'b1;
        step();
        check_val("cnt4_hold15", 64'(bus4.wb_retired), 64'd15);
        bus.wb_stall = 1'b0;
        bus.wb_flush = 1'b0;
        step();
        check_val("cnt4_wrap", 64'(bus4.wb_retired), 64'd0);
        check_val("cnt32_16", 64'(bus.wb_retired), 64'd16);

        bus.wb_stall = 1'b1;
        rst = 1'b0;
        step();
        check_val("mrst_valid", 64'(bus.wb_valid), 64'd0);
        check_val("mrst_wreg", 64'(bus.wb_wreg), 64'd0);
        check_val("mrst_destR", 64'(bus.wb_destR), 64'd0);
        check_val("mrst_dest", 64'(bus.wb_dest), 64'd0);
        check_val("mrst_type", 64'(bus.WB_ins_type), 64'd0);
        check_val("mrst_num", 64'(bus.WB_ins_number), 64'd0);
        check_val("mrst_retired", 64'(bus.wb_retired), 64'd0);
        rst = 1'b1;
        bus.wb_stall = 1'b0;
        drive(1'b1, 5'd5, 32'h0000_ABCD, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd6, 4'd7);
        step();
        check_val("post_valid", 64'(bus.wb_valid), 64'd1);
        check_val("post_dest", 64'(bus.wb_dest), 64'h0000_ABCD);
        check_val("post_wreg", 64'(bus.wb_wreg), 64'd1);
        check_val("post_retired", 64'(bus.wb_retired), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
